// File: rtl/i2s_sample_receiver.sv
// I2S receiver: captures the top SAMPLE_BITS of each slot and emits one mono (or left-only)
// sample per complete stereo frame, discarding malformed frames.
module i2s_sample_receiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int MONO_MIX    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i2sBclk,
    input  logic                          i2sLrclk,
    input  logic                          i2sData,
    output logic signed [SAMPLE_BITS-1:0] inputSample,
    output logic                          sampleReady,
    output logic                          frameError
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);

    localparam logic [1:0] StSync  = 2'd0;
    localparam logic [1:0] StDelay = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic                   r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic                   r_lr_s1, r_lr_s2, r_lr_prev;
    logic                   r_dat_s1, r_dat_s2;
    logic [1:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_left;
    logic                   r_left_ok;
    logic [SAMPLE_BITS-1:0] r_sample;
    logic                   r_ready;
    logic                   r_err;

    logic                   w_rise;
    logic                   w_lr_chg;
    logic                   w_last_bit;
    logic                   w_slot_done;
    logic                   w_short;
    logic [SAMPLE_BITS-1:0] w_word;
    logic signed [SAMPLE_BITS:0] w_sum;
    logic [SAMPLE_BITS-1:0] w_mix;
    logic [SAMPLE_BITS-1:0] w_out;

    assign w_rise     = r_bclk_s2 & ~r_bclk_d;
    assign w_lr_chg   = w_rise & (r_lr_s2 != r_lr_prev);
    assign w_last_bit = (r_cnt == CW'(SAMPLE_BITS - 1));

    // A slot exactly SAMPLE_BITS long delivers its LSB on the edge that reveals the WS change.
    assign w_slot_done = w_lr_chg & ((r_state == StDrain) | ((r_state == StShift) & w_last_bit));
    assign w_short     = w_lr_chg & (r_state == StShift) & ~w_last_bit;
    assign w_word      = (r_state == StShift) ? {r_shift[SAMPLE_BITS-2:0], r_dat_s2} : r_shift;

    assign w_sum = $signed({r_left[SAMPLE_BITS-1], r_left}) + $signed({w_word[SAMPLE_BITS-1], w_word});
    assign w_mix = SAMPLE_BITS'(w_sum >>> 1);
    assign w_out = (MONO_MIX != 0) ? w_mix : r_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_lr_prev <= 1'b0;
            r_dat_s1  <= 1'b0;
            r_dat_s2  <= 1'b0;
            r_state   <= StSync;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_left    <= '0;
            r_left_ok <= 1'b0;
            r_sample  <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_bclk_s1 <= i2sBclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lr_s1   <= i2sLrclk;
            r_lr_s2   <= r_lr_s1;
            r_dat_s1  <= i2sData;
            r_dat_s2  <= r_dat_s1;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            if (w_rise) begin
                r_lr_prev <= r_lr_s2;
            end

            case (r_state)
                StSync: begin
                    if (w_rise && r_lr_prev && !r_lr_s2) begin
                        r_left_ok <= 1'b0;
                        r_state   <= StDelay;
                    end
                end
                // The edge that revealed the WS change carried the previous slot's LSB; that
                // edge is the one-bit delay, so the next edge is this slot's MSB.
                StDelay: begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    r_state <= StShift;
                end
                StShift: begin
                    if (w_rise && !w_lr_chg) begin
                        r_shift <= {r_shift[SAMPLE_BITS-2:0], r_dat_s2};
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last_bit) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                end
                default: r_state <= StSync;
            endcase

            if (w_short) begin
                r_err     <= 1'b1;
                r_left_ok <= 1'b0;
                r_state   <= r_lr_s2 ? StSync : StDelay;
            end

            if (w_slot_done) begin
                r_state <= StDelay;
                if (r_lr_s2) begin
                    r_left    <= w_word;
                    r_left_ok <= 1'b1;
                end else begin
                    r_left_ok <= 1'b0;
                    if (r_left_ok) begin
                        r_sample <= w_out;
                        r_ready  <= 1'b1;
                    end
                end
            end
        end
    end

    assign inputSample = r_sample;
    assign sampleReady = r_ready;
    assign frameError  = r_err;

endmodule
